// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: the ID/EX decode fields and memory waits that flow
// into the controller, and the stall/flush controls that come back out.
//   master : core side (drives decode/wait info, consumes controls)
//   slave  : hazard_ctrl side
interface hazard_ctrl_if;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1_index;
  logic [4:0]  id_rs2_index;
  logic [4:0]  ex_rd_index;
  logic        ex_is_load;
  logic        ex_mul_valid;
  logic        ex_jb;
  logic        im_wait;
  logic        dm_wait;
  logic        stall;
  logic        mul_stall;
  logic        jb;
  logic        freeze;
  logic        mul_done;
  logic [31:0] stall_cnt;

  modport master (
    output id_opcode, id_rs1_index, id_rs2_index, ex_rd_index,
           ex_is_load, ex_mul_valid, ex_jb, im_wait, dm_wait,
    input  stall, mul_stall, jb, freeze, mul_done, stall_cnt
  );

  modport slave (
    input  id_opcode, id_rs1_index, id_rs2_index, ex_rd_index,
           ex_is_load, ex_mul_valid, ex_jb, im_wait, dm_wait,
    output stall, mul_stall, jb, freeze, mul_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall controller for the 5-stage RV32 core.
//   clk       : core clock
//   rst       : synchronous reset, active-high
//   bus       : hazard_ctrl_if.slave
//     in  : id_opcode, id_rs1_index, id_rs2_index, ex_rd_index, ex_is_load,
//           ex_mul_valid, ex_jb, im_wait, dm_wait
//     out : stall (load-use), mul_stall (multiplier occupancy), jb (flush),
//           freeze (memory wait), mul_done (result-valid pulse),
//           stall_cnt (cycles with stall|mul_stall|freeze)
// Priority of the controls: freeze > mul_stall > jb > stall.
module hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] stall_cnt_q;

  logic freeze, use_rs1, use_rs2, hazard;
  logic mul_stall_c, jb_c, stall_c;

  assign freeze  = bus.im_wait | bus.dm_wait;

  assign use_rs1 = !(bus.id_opcode == OP_LUI || bus.id_opcode == OP_AUIPC ||
                     bus.id_opcode == OP_JAL);
  assign use_rs2 = (bus.id_opcode == OP_RTYPE || bus.id_opcode == OP_STORE ||
                    bus.id_opcode == OP_BRANCH);

  // x0 never carries a real dependency, so rd==0 is filtered out.
  assign hazard = bus.ex_is_load && (bus.ex_rd_index != 5'd0) &&
                  ((use_rs1 && bus.id_rs1_index == bus.ex_rd_index) ||
                   (use_rs2 && bus.id_rs2_index == bus.ex_rd_index));

  // Start cycle stalls combinationally so the multiply is held from the
  // first cycle it sits in EX.
  assign mul_stall_c = !freeze &&
                       ((state == S_IDLE && bus.ex_mul_valid) || state == S_BUSY);
  assign jb_c        = bus.ex_jb && !freeze && !mul_stall_c;
  assign stall_c     = hazard && !freeze && !mul_stall_c && !jb_c;

  assign bus.freeze    = freeze;
  assign bus.mul_stall = mul_stall_c;
  assign bus.jb        = jb_c;
  assign bus.stall     = stall_c;
  assign bus.mul_done  = (state == S_DONE) && !freeze;
  assign bus.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (!freeze) begin
        case (state)
          S_IDLE: if (bus.ex_mul_valid) begin
            state <= S_BUSY;
            cnt   <= 4'(MUL_LAT - 1);
          end
          S_BUSY: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= S_DONE;
          end
          // The finished multiply is still in EX here; do not restart on it.
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
      if (stall_c || mul_stall_c || freeze) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal cases followed by
// randomized traffic, with a cycle-level behavioural model compared on every
// negative clock edge.
module tb_hazard_ctrl;
  localparam int MUL_LAT = 4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  logic clk = 1'b0;
  logic rst;
  hazard_ctrl_if bus();

  hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Model state: stall cycles of the current multiply still to come after
  // this one, and whether the result-valid cycle is pending.
  int          m_rem  = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_cnt  = 32'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected {stall, mul_stall, jb, freeze, mul_done} from model state and
  // the current inputs.
  function automatic logic [4:0] model_out();
    logic fz, ms, j, st, u1, u2, hz;
    logic [6:0] op;
    op = bus.id_opcode;
    fz = bus.im_wait | bus.dm_wait;
    ms = !fz && !m_done && (m_rem > 0 || bus.ex_mul_valid);
    j  = bus.ex_jb && !fz && !ms;
    u1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    u2 = (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
    hz = bus.ex_is_load && bus.ex_rd_index != 0 &&
         ((u1 && bus.id_rs1_index == bus.ex_rd_index) ||
          (u2 && bus.id_rs2_index == bus.ex_rd_index));
    st = hz && !fz && !ms && !j;
    return {st, ms, j, fz, !fz && m_done};
  endfunction

  logic [4:0] eo_u;
  always @(posedge clk) begin
    eo_u = model_out();
    if (rst) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_cnt  <= 32'd0;
    end else begin
      if (!eo_u[1]) ;
      if (!(bus.im_wait | bus.dm_wait)) begin
        if (m_done) m_done <= 1'b0;
        else if (m_rem > 0) begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_done <= 1'b1;
        end else if (bus.ex_mul_valid) m_rem <= MUL_LAT - 1;
      end
      if (eo_u[4] | eo_u[3] | eo_u[1]) m_cnt <= m_cnt + 32'd1;
    end
  end

  logic [4:0] eo_c;
  always @(negedge clk) begin
    if (chk_en) begin
      eo_c = model_out();
      check("stall",     {31'd0, bus.stall},     {31'd0, eo_c[4]});
      check("mul_stall", {31'd0, bus.mul_stall}, {31'd0, eo_c[3]});
      check("jb",        {31'd0, bus.jb},        {31'd0, eo_c[2]});
      check("freeze",    {31'd0, bus.freeze},    {31'd0, eo_c[1]});
      check("mul_done",  {31'd0, bus.mul_done},  {31'd0, eo_c[0]});
      check("stall_cnt", bus.stall_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.id_opcode    = OP_IMM;
    bus.id_rs1_index = 5'd0;
    bus.id_rs2_index = 5'd0;
    bus.ex_rd_index  = 5'd0;
    bus.ex_is_load   = 1'b0;
    bus.ex_mul_valid = 1'b0;
    bus.ex_jb        = 1'b0;
    bus.im_wait      = 1'b0;
    bus.dm_wait      = 1'b0;
  endtask

  logic [6:0] ops [8];
  logic [31:0] base;

  initial begin
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_RTYPE, OP_STORE, OP_BRANCH, OP_LOAD, OP_IMM};
    idle_in();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_outs", {27'd0, bus.stall, bus.mul_stall, bus.jb, bus.freeze, bus.mul_done}, 32'd0);
    check("rst_cnt", bus.stall_cnt, 32'd0);
    tick();

    // Load-use on rs2 of an ADD: one stall cycle, counter 0 -> 1
    bus.ex_is_load = 1'b1; bus.ex_rd_index = 5'd5;
    bus.id_opcode = OP_RTYPE; bus.id_rs1_index = 5'd1; bus.id_rs2_index = 5'd5;
    @(negedge clk);
    check("lu_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    bus.ex_is_load = 1'b0;
    @(negedge clk);
    check("lu_clear", {31'd0, bus.stall}, 32'd0);
    check("lu_cnt", bus.stall_cnt, 32'd1);
    tick();

    // x0 destination never stalls
    bus.ex_is_load = 1'b1; bus.ex_rd_index = 5'd0;
    bus.id_opcode = OP_RTYPE; bus.id_rs1_index = 5'd0; bus.id_rs2_index = 5'd3;
    @(negedge clk);
    check("x0_filter", {31'd0, bus.stall}, 32'd0);
    tick();
    // LUI does not read rs1
    bus.ex_rd_index = 5'd7; bus.id_opcode = OP_LUI; bus.id_rs1_index = 5'd7;
    @(negedge clk);
    check("lui_filter", {31'd0, bus.stall}, 32'd0);
    tick();

    // Flush beats load-use; freeze beats flush
    bus.id_opcode = OP_IMM; bus.ex_jb = 1'b1;
    @(negedge clk);
    check("prio_jb", {30'd0, bus.jb, bus.stall}, 32'd2);
    tick();
    bus.ex_is_load = 1'b0; bus.im_wait = 1'b1;
    @(negedge clk);
    check("prio_fz", {30'd0, bus.jb, bus.freeze}, 32'd1);
    tick();
    idle_in();
    tick();

    // Multiply held in EX, then a back-to-back second multiply
    base = m_cnt;
    bus.ex_mul_valid = 1'b1;
    for (int i = 0; i < MUL_LAT; i++) begin
      @(negedge clk);
      check("mul_win", {31'd0, bus.mul_stall}, 32'd1);
      tick();
    end
    @(negedge clk);
    check("mul_done", {30'd0, bus.mul_done, bus.mul_stall}, 32'd2);
    check("mul_cnt", bus.stall_cnt, base + 32'd4);
    tick();
    for (int i = 0; i < MUL_LAT; i++) begin
      @(negedge clk);
      check("mul2_win", {31'd0, bus.mul_stall}, 32'd1);
      tick();
    end
    bus.ex_mul_valid = 1'b0;
    @(negedge clk);
    check("mul2_done", {31'd0, bus.mul_done}, 32'd1);
    tick();
    tick();

    // Freeze for two cycles inside BUSY stretches the window
    base = m_cnt;
    bus.ex_mul_valid = 1'b1;
    tick(); tick();
    bus.dm_wait = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("fz_hold", {30'd0, bus.mul_stall, bus.freeze}, 32'd1);
      tick();
    end
    bus.dm_wait = 1'b0;
    tick(); tick();
    bus.ex_mul_valid = 1'b0;
    @(negedge clk);
    check("fz_done", {31'd0, bus.mul_done}, 32'd1);
    check("fz_cnt", bus.stall_cnt, base + 32'd6);
    tick();
    tick();

    // Reset mid-multiply abandons it
    bus.ex_mul_valid = 1'b1;
    tick(); tick();
    rst = 1'b1; bus.ex_mul_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rmul_outs", {27'd0, bus.stall, bus.mul_stall, bus.jb, bus.freeze, bus.mul_done}, 32'd0);
    check("rmul_cnt", bus.stall_cnt, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      check("rmul_nodone", {31'd0, bus.mul_done}, 32'd0);
    end
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst              = ($urandom_range(199) == 0);
      bus.id_opcode    = ops[$urandom_range(7)];
      bus.id_rs1_index = 5'($urandom_range(3));
      bus.id_rs2_index = 5'($urandom_range(3));
      bus.ex_rd_index  = 5'($urandom_range(3));
      bus.ex_is_load   = ($urandom_range(1) == 0);
      bus.ex_mul_valid = ($urandom_range(5) == 0);
      bus.ex_jb        = ($urandom_range(7) == 0);
      bus.im_wait      = ($urandom_range(9) == 0);
      bus.dm_wait      = ($urandom_range(9) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32 core. It generates the `stall`, `mul_stall` and `jb` controls consumed by the ID stage and its IF/ID register. It sequences the multi-cycle multiplier through a small FSM and detects load-use hazards from ID/EX register indices. It also applies memory-wait freezes and keeps a stall-cycle performance counter.

## Interface

Parameters:
- `MUL_LAT`, default 4: multiplier occupancy in EX, in cycles. Legal range 2..15.

Ports:
- `clk` input, 1: core clock.
- `rst` input, 1: synchronous reset, active-high.
- `id_opcode` input, 7: opcode of the instruction in ID.
- `id_rs1_index` input, 5: rs1 of the instruction in ID.
- `id_rs2_index` input, 5: rs2 of the instruction in ID.
- `ex_rd_index` input, 5: rd of the instruction in EX.
- `ex_is_load` input, 1: EX holds a load.
- `ex_mul_valid` input, 1: EX holds an M-extension multiply.
- `ex_jb` input, 1: branch taken or jump resolved in EX.
- `im_wait` input, 1: instruction memory not ready.
- `dm_wait` input, 1: data memory not ready.
- `stall` output, 1: load-use stall. Hold PC and IF/ID; bubble into ID/EX.
- `mul_stall` output, 1: hold PC, IF/ID, ID/EX and EX; bubble into EX/MEM.
- `jb` output, 1: flush IF/ID and ID/EX; redirect PC.
- `freeze` output, 1: hold every pipeline register.
- `mul_done` output, 1: one-cycle pulse when the multiply result is valid in EX.
- `stall_cnt` output, 32: count of cycles with `stall`, `mul_stall` or `freeze` high.

## Operation

- Freeze:
  - `freeze = im_wait | dm_wait`.
  - While `freeze` is high, `stall`, `mul_stall` and `jb` are 0, and the FSM and counter hold.
- Output priority: freeze > mul_stall > jb > stall.
- Register use, decoded from `id_opcode`:
  - rs1 is used unless the opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - rs2 is used only for R-type 0110011, STORE 0100011 and BRANCH 1100011.
- Load-use hazard:
  - Condition: `ex_is_load` and `ex_rd_index != 0` and ((rs1 used and rs1 == rd) or (rs2 used and rs2 == rd)).
  - `stall` = hazard and not `freeze`, `mul_stall` or `jb`.
- Flush: `jb` = `ex_jb` and not `freeze` or `mul_stall`.
- Multiplier FSM, 2-bit state and 4-bit `cnt`:
  - IDLE: if `ex_mul_valid` and not `freeze`, go to BUSY and set `cnt = MUL_LAT-1`.
  - BUSY: decrement `cnt`. If `cnt == 1`, go to DONE.
  - DONE: go to IDLE. `ex_mul_valid` is ignored in DONE, because the same multiply is still in EX.
- `mul_stall` = (IDLE and `ex_mul_valid`) or BUSY, gated by not `freeze`. This is combinational on the start cycle.
- `mul_done` = DONE and not `freeze`.
- `stall_cnt`: increments by 1 on each cycle where `stall | mul_stall | freeze` is high. It wraps at 2^32.
- Reset:
  - State goes to IDLE; `cnt` and `stall_cnt` go to 0.
  - All outputs read 0 in the cycle after reset, given idle inputs.
  - Reset during BUSY abandons the multiply, with no `mul_done`.

## Timing

- `stall`, `jb` and `freeze` are combinational; they have zero latency from their inputs.
- A multiply entering EX at cycle t:
  - `mul_stall` is high for cycles t .. t+MUL_LAT-1.
  - `mul_done` is high and `mul_stall` is low at t+MUL_LAT.
  - The FSM is in IDLE at t+MUL_LAT+1.
- Back-to-back multiplies: the second multiply starts at t+MUL_LAT+1. That gives one non-stalled cycle between the two stall windows.
- Freeze during BUSY: each frozen cycle extends the window by one cycle, and `mul_stall` reads 0 while frozen.
- A load-use stall lasts exactly one cycle: the load advances to MEM, and the hazard clears.
- `ex_jb` together with a load-use hazard: `jb` = 1 and `stall` = 0.
- `stall_cnt` updates on the clock edge after the qualifying cycle.

## Test plan

- Load-use: EX has `ex_is_load`=1 and `ex_rd_index`=5; ID has ADD (0110011) with rs2=5. Required: `stall`=1 for 1 cycle, and `stall_cnt` goes 0->1.
- x0 and unused-register filter:
  - Load with rd=0 and an ID consumer of rs1=0 -> `stall`=0.
  - LUI in ID with rs1 field matching rd=7 -> `stall`=0.
- Multiply with MUL_LAT=4:
  - `ex_mul_valid` held from cycle t -> `mul_stall`=1 at t..t+3, `mul_done`=1 at t+4, `stall_cnt`=4.
  - A second multiply held in EX -> its `mul_stall` starts at t+5.
- Freeze inside BUSY: assert `dm_wait` for 2 cycles at t+2. Required: `mul_stall`=0 and `freeze`=1 for those cycles, then `mul_done` at t+6, and `stall_cnt`=6.
- Priority: `ex_jb`=1 together with a load-use hazard -> `jb`=1, `stall`=0. `ex_jb`=1 together with `im_wait`=1 -> `jb`=0, `freeze`=1.
- Reset mid-multiply: assert `rst` at t+2. Required: all outputs 0 on the next cycle and `stall_cnt`=0; `mul_done` never pulses.
